// File: rtl/instr_issue_queue_pkg.sv
// Shared definitions for the instruction issue queue: instruction word layout,
// opcode and register-select encodings, and the issue FSM state type.
package instr_issue_queue_pkg;

  // Instruction word layout: [15:14] opcode, [13:11] reserved, [10:9] reg, [8:0] addr
  localparam int INSTR_W  = 16;
  localparam int OP_LSB   = 14;
  localparam int OP_W     = 2;
  localparam int RSV_LSB  = 11;
  localparam int RSV_W    = 3;
  localparam int REG_LSB  = 9;
  localparam int REG_W    = 2;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 9;

  // Hold counter width covers hold windows of 1..255 cycles
  localparam int HOLD_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } opcode_e;

  typedef enum logic [REG_W-1:0] {
    REG_A1 = 2'b00,
    REG_A2 = 2'b01,
    REG_A3 = 2'b10,
    REG_A4 = 2'b11
  } regsel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } issue_state_e;

  // Extract the opcode field of an instruction word
  function automatic opcode_e instr_opcode(input logic [INSTR_W-1:0] word);
    return opcode_e'(word[OP_LSB +: OP_W]);
  endfunction

endpackage

// File: rtl/instr_issue_queue_fifo.sv
// Synchronous FIFO with a registered read port. The read word stays on rd_data
// until the next pop, so it can drive a downstream port directly.
module sync_fifo
  import instr_issue_queue_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_ok;
  logic             wr_ok;

  // Clear beats both ports; a write into a full FIFO is taken only when a pop frees a slot
  assign rd_ok = rd_en && !clr && (level_reg != '0);
  assign wr_ok = wr_en && !clr && ((level_reg != FULL_LEVEL) || rd_ok);

  assign rd_data = rd_data_reg;
  assign level   = level_reg;

  // Storage write port; left without reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Registered read: old contents are read even when the write hits the same slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
    end else if (rd_ok) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clr) begin
      rd_ptr_reg <= wr_ptr_reg;
      level_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_ok && !rd_ok) begin
        level_reg <= level_reg + LW'(1);
      end else if (!wr_ok && rd_ok) begin
        level_reg <= level_reg - LW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers instruction words and presents them one at a
// time on the processor port, each held for a fixed window of HOLD_CYCLES.
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [INSTR_W-1:0]     instruction,
  output logic                   issue_busy,
  output logic                   issue_pulse,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            issued_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]     FULL_LEVEL = LW'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

  issue_state_e      state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              busy_reg;
  logic              pulse_reg;
  logic [15:0]       count_reg;
  logic              window_done;
  logic              do_pop;

  // A new word may issue when idle or in the last cycle of the current window
  assign window_done = (state_reg == ST_IDLE) || (hold_cnt_reg == '0);
  assign do_pop      = window_done && (level != '0) && !flush;
  assign in_ready    = (level != FULL_LEVEL);

  assign issue_busy   = busy_reg;
  assign issue_pulse  = pulse_reg;
  assign issued_count = count_reg;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .wr_en   (in_valid),
    .wr_data (in_instr),
    .rd_en   (do_pop),
    .rd_data (instruction),
    .level   (level)
  );

  // Issue FSM: every pop opens a new hold window; flush never cuts a window short
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      pulse_reg    <= 1'b0;
      count_reg    <= '0;
    end else begin
      pulse_reg <= do_pop;
      if (do_pop) begin
        state_reg    <= ST_HOLD;
        hold_cnt_reg <= HOLD_LOAD;
        busy_reg     <= 1'b1;
        count_reg    <= count_reg + 16'd1;
      end else begin
        case (state_reg)
          ST_HOLD: begin
            if (hold_cnt_reg == '0) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
